// File: rtl/kv_pkg.sv
// Shared KV-cache geometry, field widths and the score FSM state type.
package kv_pkg;

  localparam int N_LAYER  = 4;
  localparam int N_HEAD   = 8;
  localparam int N_POS    = 256;
  localparam int HEAD_DIM = 16;

  localparam int LAYER_W = $clog2(N_LAYER);
  localparam int HEAD_W  = $clog2(N_HEAD);
  localparam int POS_W   = $clog2(N_POS);
  localparam int DIM_W   = $clog2(HEAD_DIM);
  localparam int DATA_W  = 8;
  localparam int PROD_W  = 2 * DATA_W;
  // Full-precision sum of HEAD_DIM signed 8x8 products.
  localparam int ACC_W   = PROD_W + DIM_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT,
    S_DONE
  } qk_state_e;

  typedef enum logic {
    KV_SEL_K = 1'b0,
    KV_SEL_V = 1'b1
  } kv_sel_e;

endpackage

// File: rtl/qk_mac.sv
// Signed 8x8 multiply-accumulate with synchronous clear; exposes the next
// accumulator value so the owner can capture a sum on the edge it completes.
module qk_mac
  import kv_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  acc_d_o
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    acc_d = acc_q;
    prod  = PROD_W'(a_i) * PROD_W'(b_i);
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_d_o = acc_d;

endmodule

// File: rtl/qk_score.sv
// Query-key dot-product scorer over a range of KV-cache positions.
// Build macro QK_SCALE_EN: scores are the accumulator arithmetic-shifted right by 2.
module qk_score #(
  parameter int HEAD_DIM = 16,
  parameter int SCORE_W  = 20
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [kv_pkg::LAYER_W-1:0]        layer_i,
  input  logic [kv_pkg::HEAD_W-1:0]         head_i,
  input  logic [kv_pkg::POS_W-1:0]          pos_max_i,
  input  logic                              q_we_i,
  input  logic [kv_pkg::DIM_W-1:0]          q_idx_i,
  input  logic signed [kv_pkg::DATA_W-1:0]  q_data_i,
  output logic [kv_pkg::LAYER_W-1:0]        kv_layer_o,
  output logic                              kv_sel_o,
  output logic [kv_pkg::HEAD_W-1:0]         kv_head_o,
  output logic [kv_pkg::POS_W-1:0]          kv_pos_o,
  output logic [kv_pkg::DIM_W-1:0]          kv_dim_o,
  input  logic signed [kv_pkg::DATA_W-1:0]  kv_rdata_i,
  output logic                              score_valid_o,
  input  logic                              score_ready_i,
  output logic signed [SCORE_W-1:0]         score_o,
  output logic [kv_pkg::POS_W-1:0]          score_pos_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int LAYER_W = kv_pkg::LAYER_W;
  localparam int HEAD_W  = kv_pkg::HEAD_W;
  localparam int POS_W   = kv_pkg::POS_W;
  localparam int DIM_W   = kv_pkg::DIM_W;
  localparam int DATA_W  = kv_pkg::DATA_W;
  localparam int ACC_W   = kv_pkg::ACC_W;
  localparam logic [DIM_W-1:0] LAST_DIM = DIM_W'(HEAD_DIM - 1);

  kv_pkg::qk_state_e         state_q;
  logic [LAYER_W-1:0]        layer_q;
  logic [HEAD_W-1:0]         head_q;
  logic [POS_W-1:0]          pos_q;
  logic [POS_W-1:0]          pos_max_q;
  logic [DIM_W-1:0]          dim_q;
  logic                      drain_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      valid_q;
  logic signed [SCORE_W-1:0] score_q;
  logic [POS_W-1:0]          score_pos_q;
  logic signed [DATA_W-1:0]  q_q [HEAD_DIM];

  // Read-latency tracker: marks which cycles carry a K byte and for which dim.
  logic [1:0]                rd_vld_q;
  logic [DIM_W-1:0]          rd_dim1_q;
  logic [DIM_W-1:0]          rd_dim2_q;

  logic                      handshake;
  logic                      mac_clr;
  logic signed [ACC_W-1:0]   mac_acc_d;
  logic signed [SCORE_W-1:0] score_d;

  assign handshake = valid_q & score_ready_i;
  assign mac_clr   = ((state_q == kv_pkg::S_IDLE) && start_i) || handshake;

  qk_mac u_mac (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (mac_clr),
    .en_i    (rd_vld_q[1]),
    .a_i     (kv_rdata_i),
    .b_i     (q_q[rd_dim2_q]),
    .acc_d_o (mac_acc_d)
  );

`ifdef QK_SCALE_EN
  assign score_d = SCORE_W'(mac_acc_d >>> 2);
`else
  assign score_d = SCORE_W'(mac_acc_d);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_vld_q  <= '0;
      rd_dim1_q <= '0;
      rd_dim2_q <= '0;
    end else begin
      rd_vld_q  <= {rd_vld_q[0], state_q == kv_pkg::S_ISSUE};
      rd_dim1_q <= dim_q;
      rd_dim2_q <= rd_dim1_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= kv_pkg::S_IDLE;
      layer_q     <= '0;
      head_q      <= '0;
      pos_q       <= '0;
      pos_max_q   <= '0;
      dim_q       <= '0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      score_q     <= '0;
      score_pos_q <= '0;
      // NOTE: the query file is reset like any other register; a pass started
      // straight after reset must see zero queries, not stale or unknown ones.
      for (int i = 0; i < HEAD_DIM; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        kv_pkg::S_IDLE: begin
          if (q_we_i) begin
            q_q[q_idx_i] <= q_data_i;
          end
          if (start_i) begin
            layer_q   <= layer_i;
            head_q    <= head_i;
            pos_max_q <= pos_max_i;
            pos_q     <= '0;
            dim_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= kv_pkg::S_ISSUE;
          end
        end
        kv_pkg::S_ISSUE: begin
          if (dim_q == LAST_DIM) begin
            dim_q   <= '0;
            drain_q <= 1'b0;
            state_q <= kv_pkg::S_DRAIN;
          end else begin
            dim_q <= dim_q + 1'b1;
          end
        end
        kv_pkg::S_DRAIN: begin
          if (drain_q) begin
            drain_q     <= 1'b0;
            valid_q     <= 1'b1;
            score_q     <= score_d;
            score_pos_q <= pos_q;
            state_q     <= kv_pkg::S_OUT;
          end else begin
            drain_q <= 1'b1;
          end
        end
        kv_pkg::S_OUT: begin
          if (score_ready_i) begin
            valid_q <= 1'b0;
            // Compare before incrementing so pos_max = 255 ends without wrapping.
            if (pos_q < pos_max_q) begin
              pos_q   <= pos_q + 1'b1;
              state_q <= kv_pkg::S_ISSUE;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= kv_pkg::S_DONE;
            end
          end
        end
        kv_pkg::S_DONE: begin
          state_q <= kv_pkg::S_IDLE;
        end
        default: begin
          state_q <= kv_pkg::S_IDLE;
        end
      endcase
    end
  end

  assign kv_layer_o    = layer_q;
  assign kv_sel_o      = kv_pkg::KV_SEL_K;
  assign kv_head_o     = head_q;
  assign kv_pos_o      = pos_q;
  assign kv_dim_o      = dim_q;
  assign score_valid_o = valid_q;
  assign score_o       = score_q;
  assign score_pos_o   = score_pos_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_qk_score.sv
// Directed bench for qk_score with a two-cycle-latency K-cache model.
module tb_qk_score;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        layer;
  logic [2:0]        head;
  logic [7:0]        pos_max;
  logic              q_we;
  logic [3:0]        q_idx;
  logic signed [7:0] q_data;
  logic [1:0]        kv_layer_o;
  logic              kv_sel_o;
  logic [2:0]        kv_head_o;
  logic [7:0]        kv_pos_o;
  logic [3:0]        kv_dim_o;
  logic              score_valid_o;
  logic              score_ready;
  logic signed [19:0] score_o;
  logic [7:0]        score_pos_o;
  logic              busy_o;
  logic              done_o;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_edge = 0;
  int done_cnt = 0;
  int hs_pos[$];
  int hs_score[$];
  int hs_edge[$];

  byte kmem [0:131071];
  byte rd1, rd2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rd1 <= kmem[{kv_layer_o, kv_head_o, kv_pos_o, kv_dim_o}];
    rd2 <= rd1;
  end

  always @(negedge clk) begin
    if (!rst && score_valid_o && score_ready) begin
      hs_pos.push_back(int'(score_pos_o));
      hs_score.push_back(int'(score_o));
      hs_edge.push_back(cyc + 1);
    end
    if (done_o) done_cnt++;
  end

  qk_score #(.HEAD_DIM(16), .SCORE_W(20)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .layer_i(layer), .head_i(head),
    .pos_max_i(pos_max), .q_we_i(q_we), .q_idx_i(q_idx), .q_data_i(q_data),
    .kv_layer_o(kv_layer_o), .kv_sel_o(kv_sel_o), .kv_head_o(kv_head_o),
    .kv_pos_o(kv_pos_o), .kv_dim_o(kv_dim_o), .kv_rdata_i(rd2),
    .score_valid_o(score_valid_o), .score_ready_i(score_ready),
    .score_o(score_o), .score_pos_o(score_pos_o), .busy_o(busy_o), .done_o(done_o)
  );

  function automatic int scaled(input int raw);
`ifdef QK_SCALE_EN
    return raw >>> 2;
`else
    return raw;
`endif
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write_q(input int idx, input int v);
    q_we = 1'b1; q_idx = 4'(idx); q_data = 8'(v);
    step();
    q_we = 1'b0;
  endtask

  task automatic write_q_all(input int v);
    for (int i = 0; i < 16; i++) write_q(i, v);
  endtask

  task automatic set_k(input int l, input int h, input int p, input int d, input int v);
    kmem[(l << 15) | (h << 12) | (p << 4) | d] = byte'(v);
  endtask

  task automatic do_start(input int l, input int h, input int pm);
    layer = 2'(l); head = 3'(h); pos_max = 8'(pm);
    start = 1'b1; start_edge = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit timed_out);
    int i = 0;
    while (done_cnt == d0 && i < budget) begin step(); i++; end
    timed_out = (done_cnt == d0);
  endtask

  task automatic test_reset;
    bit to; int hb; int d0;
    rst = 1'b1; start = 1'b0; layer = '0; head = '0; pos_max = '0;
    q_we = 1'b0; q_idx = '0; q_data = '0; score_ready = 1'b1;
    step(3);
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    n_cmp++; if (score_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", score_valid_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done_o); end
    n_cmp++; if ({score_o, score_pos_o} !== 28'd0) begin n_fail++; $display("FAIL reset_score: got %0d@%0d want 0@0", score_o, score_pos_o); end
    n_cmp++; if ({kv_layer_o, kv_sel_o, kv_head_o, kv_pos_o, kv_dim_o} !== 18'd0) begin
      n_fail++; $display("FAIL reset_kv_addr: got %h want 0", {kv_layer_o, kv_sel_o, kv_head_o, kv_pos_o, kv_dim_o}); end
    rst = 1'b0;
    step(2);
    // Queries never written: reset value must give a zero score.
    for (int d = 0; d < 16; d++) set_k(2, 5, 0, d, 5);
    hb = hs_pos.size(); d0 = done_cnt;
    do_start(2, 5, 0);
    wait_done(d0, 100, to);
    step(2);
    n_cmp++; if (to || hs_pos.size() != hb + 1) begin n_fail++; $display("FAIL q_reset_count: got %0d want 1", hs_pos.size() - hb); end
    else begin
      n_cmp++; if (hs_score[hb] != 0) begin n_fail++; $display("FAIL q_reset_score: got %0d want 0", hs_score[hb]); end
    end
  endtask

  task automatic test_basic;
    bit to; int hb; int d0;
    write_q_all(1);
    for (int d = 0; d < 16; d++) set_k(0, 0, 0, d, 1);
    hb = hs_pos.size(); d0 = done_cnt;
    do_start(0, 0, 0);
    wait_done(d0, 100, to);
    step(3);
    n_cmp++; if (to || hs_pos.size() != hb + 1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", hs_pos.size() - hb); end
    else begin
      n_cmp++; if (hs_score[hb] != scaled(16) || hs_pos[hb] != 0) begin
        n_fail++; $display("FAIL basic_score: got %0d@%0d want %0d@0", hs_score[hb], hs_pos[hb], scaled(16)); end
    end
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_negative;
    bit to; int hb; int d0; int bad = 0;
    write_q_all(-128);
    for (int d = 0; d < 16; d++) set_k(1, 3, 42, d, -128);
    hb = hs_pos.size(); d0 = done_cnt;
    do_start(1, 3, 42);
    step(2);
    n_cmp++; if ({kv_layer_o, kv_head_o, kv_sel_o, busy_o} !== {2'd1, 3'd3, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL neg_addr: got L%0d H%0d sel%0b busy%0b want L1 H3 sel0 busy1", kv_layer_o, kv_head_o, kv_sel_o, busy_o); end
    wait_done(d0, 1200, to);
    step(2);
    n_cmp++; if (to || hs_pos.size() != hb + 43) begin n_fail++; $display("FAIL neg_count: got %0d want 43", hs_pos.size() - hb); end
    else begin
      for (int i = 0; i < 42; i++) if (hs_score[hb + i] != 0 || hs_pos[hb + i] != i) bad++;
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL neg_zero_positions: got %0d bad want 0", bad); end
      n_cmp++; if (hs_score[hb + 42] != scaled(262144) || hs_pos[hb + 42] != 42) begin
        n_fail++; $display("FAIL neg_score: got %0d@%0d want %0d@42", hs_score[hb + 42], hs_pos[hb + 42], scaled(262144)); end
    end
  endtask

  task automatic test_single_dim;
    bit to; int hb; int d0;
    write_q_all(0);
    write_q(0, 127);
    for (int d = 0; d < 16; d++) set_k(2, 1, 7, d, (d == 0) ? -128 : 77);
    hb = hs_pos.size(); d0 = done_cnt;
    do_start(2, 1, 7);
    wait_done(d0, 400, to);
    step(2);
    n_cmp++; if (to || hs_pos.size() != hb + 8) begin n_fail++; $display("FAIL dim0_count: got %0d want 8", hs_pos.size() - hb); end
    else begin
      n_cmp++; if (hs_score[hb + 7] != scaled(-16256) || hs_pos[hb + 7] != 7) begin
        n_fail++; $display("FAIL dim0_score: got %0d@%0d want %0d@7", hs_score[hb + 7], hs_pos[hb + 7], scaled(-16256)); end
    end
  endtask

  task automatic test_mixed;
    bit to; int hb; int d0;
    for (int i = 0; i < 16; i++) write_q(i, i - 8);
    for (int d = 0; d < 16; d++) set_k(2, 2, 0, d, d + 1);
    hb = hs_pos.size(); d0 = done_cnt;
    do_start(2, 2, 0);
    wait_done(d0, 100, to);
    step(2);
    // sum over d of (d-8)*(d+1) = 272
    n_cmp++; if (to || hs_pos.size() != hb + 1 || hs_score[hb] != scaled(272)) begin
      n_fail++; $display("FAIL mixed_score: got %0d (n=%0d) want %0d", (hs_pos.size() > hb) ? hs_score[hb] : -1, hs_pos.size() - hb, scaled(272)); end
  endtask

  task automatic test_backpressure;
    bit to; int hb; int d0; int unstable = 0; int s0; int p0; int n;
    write_q_all(2);
    for (int p = 0; p < 3; p++) for (int d = 0; d < 16; d++) set_k(3, 7, p, d, p + 1);
    hb = hs_pos.size(); d0 = done_cnt;
    score_ready = 1'b0;
    do_start(3, 7, 2);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!score_valid_o && n < 60) begin step(); n++; end
      n_cmp++; if (!score_valid_o) begin n_fail++; $display("FAIL bp_valid_%0d: got 0 want 1 within 60 cycles", k); end
      s0 = int'(score_o); p0 = int'(score_pos_o);
      n_cmp++; if (p0 != k || s0 != scaled(32 * (k + 1))) begin
        n_fail++; $display("FAIL bp_score_%0d: got %0d@%0d want %0d@%0d", k, s0, p0, scaled(32 * (k + 1)), k); end
      if (k == 1) begin
        repeat (5) begin
          step();
          if (int'(score_o) != s0 || int'(score_pos_o) != p0 || score_valid_o !== 1'b1) unstable++;
        end
      end
      score_ready = 1'b1;
      step();
      score_ready = 1'b0;
    end
    wait_done(d0, 60, to);
    step(5);
    n_cmp++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
    n_cmp++; if (to || done_cnt - d0 != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt - d0); end
    n_cmp++; if (hs_pos.size() != hb + 3 || hs_pos[hb] != 0 || hs_pos[hb + 1] != 1 || hs_pos[hb + 2] != 2) begin
      n_fail++; $display("FAIL bp_order: got %0d handshakes want 0,1,2", hs_pos.size() - hb); end
    score_ready = 1'b1;
  endtask

  task automatic test_start_ignored_and_reset;
    bit to; int hb; int d0; int d1; int hs_n; int n = 0;
    write_q_all(1);
    hb = hs_pos.size(); d0 = done_cnt;
    do_start(0, 0, 5);
    step(3);
    layer = 2'd2; head = 3'd5; pos_max = 8'd0; start = 1'b1;
    q_we = 1'b1; q_idx = 4'd0; q_data = 8'sd99;
    step();
    start = 1'b0; q_we = 1'b0;
    n_cmp++; if ({kv_layer_o, kv_head_o, busy_o} !== {2'd0, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL busy_start: got L%0d H%0d busy%0b want L0 H0 busy1", kv_layer_o, kv_head_o, busy_o); end
    while (hs_pos.size() == hb && n < 60) begin step(); n++; end
    n_cmp++; if (hs_pos.size() == hb || hs_score[hb] != scaled(16)) begin
      n_fail++; $display("FAIL busy_qwrite: got %0d want %0d", (hs_pos.size() > hb) ? hs_score[hb] : -1, scaled(16)); end
    n = 0;
    while (kv_pos_o != 8'd3 && n < 100) begin step(); n++; end
    step(4);
    rst = 1'b1;
    #1;
    n_cmp++; if ({busy_o, score_valid_o, kv_pos_o} !== 10'd0) begin
      n_fail++; $display("FAIL midpass_reset: got busy%0b valid%0b pos%0d want 0 0 0", busy_o, score_valid_o, kv_pos_o); end
    step(2);
    rst = 1'b0;
    hs_n = hs_pos.size();
    step(60);
    n_cmp++; if (hs_pos.size() != hs_n || hs_n - hb != 3 || done_cnt != d0) begin
      n_fail++; $display("FAIL post_reset_quiet: got %0d scores %0d dones want 3 0", hs_pos.size() - hb, done_cnt - d0); end
    write_q_all(1);
    hb = hs_pos.size(); d1 = done_cnt;
    do_start(0, 0, 0);
    wait_done(d1, 100, to);
    step(2);
    n_cmp++; if (to || hs_pos.size() != hb + 1 || hs_score[hb] != scaled(16)) begin
      n_fail++; $display("FAIL fresh_start: got n=%0d want one score %0d", hs_pos.size() - hb, scaled(16)); end
  endtask

  task automatic test_timing;
    bit to; int hb; int d0; int se;
    hb = hs_pos.size(); d0 = done_cnt;
    do_start(0, 0, 3);
    se = start_edge;
    wait_done(d0, 200, to);
    step(2);
    n_cmp++; if (to || hs_pos.size() != hb + 4) begin n_fail++; $display("FAIL timing_count: got %0d want 4", hs_pos.size() - hb); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (hs_edge[hb + i] - se != 19 * (i + 1)) begin
          n_fail++; $display("FAIL timing_edge_%0d: got %0d want %0d", i, hs_edge[hb + i] - se, 19 * (i + 1)); end
      end
    end
  endtask

  task automatic test_pos_max_255;
    bit to; int hb; int d0; int bad = 0;
    for (int d = 0; d < 16; d++) set_k(2, 6, 255, d, 1);
    hb = hs_pos.size(); d0 = done_cnt;
    do_start(2, 6, 255);
    wait_done(d0, 6000, to);
    step(3);
    n_cmp++; if (to || hs_pos.size() != hb + 256) begin n_fail++; $display("FAIL p255_count: got %0d want 256", hs_pos.size() - hb); end
    else begin
      for (int i = 0; i < 256; i++) if (hs_pos[hb + i] != i) bad++;
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL p255_order: got %0d bad want 0", bad); end
      n_cmp++; if (hs_score[hb + 255] != scaled(16) || hs_score[hb] != 0) begin
        n_fail++; $display("FAIL p255_score: got %0d/%0d want 0/%0d", hs_score[hb], hs_score[hb + 255], scaled(16)); end
    end
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL p255_done: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_single_dim();
    test_mixed();
    test_backpressure();
    test_start_ignored_and_reset();
    test_timing();
    test_pos_max_255();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
